mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have parameter STARVE_LIMIT, default 8: consecutive cycles a pending dbg request may lose before it is forced to win.
REQ-002 The block SHALL have parameter CNT_W, default 16: width of the performance counters.
REQ-003 Clocking and reset SHALL be: one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  system clock, all state on rising edge.
REQ-005 Rst  in  1  asynchronous active-low reset.
REQ-006 core_req  in  1  Memory-stage access request, held until core_ack.
REQ-007 core_we / core_en / core_addr / core_din  in  1/4/32/32  core write flag, byte enables, byte address, write data.
REQ-008 core_rdata  out  32  read data, valid with core_ack.
REQ-009 core_ack  out  1  one-cycle completion pulse to the core.
REQ-010 core_stall  out  1  pipeline stall request to the core.
REQ-011 dbg_req / dbg_we / dbg_en / dbg_addr / dbg_din  in  1/1/4/32/32  debug/UART requester, with the same semantics as the core requester.
REQ-012 dbg_rdata  out  32  debug read data.
REQ-013 dbg_ack  out  1  debug completion pulse.
REQ-014 mem_en / mem_wea / mem_rea / mem_addr / mem_din  out  4/1/1/32/32  shared data-memory port.
REQ-015 mem_dout  in  32  memory read data, valid one cycle after mem_en.
REQ-016 core_gnt_cnt / dbg_gnt_cnt  out  CNT_W/CNT_W  grant counters.

Function
REQ-017 The FSM SHALL have the states IDLE, ISSUE and RESP.
- IDLE -> ISSUE when any request is pending.
- ISSUE -> RESP always.
- RESP -> IDLE always.
REQ-018 In IDLE, arbitration SHALL give the core fixed priority, except that dbg wins when starve_cnt equals STARVE_LIMIT.
REQ-019 On IDLE->ISSUE, the winner's we/en/addr/din SHALL be registered, together with a 1-bit owner flag.
REQ-020 In ISSUE, the block SHALL drive mem_en from the latched enable, mem_wea equal to the latched we, mem_rea equal to the inverted latched we, and mem_addr/mem_din from the latched values, for exactly one cycle.
- mem_en SHALL be 4'b0000 in every other state.
- mem_wea and mem_rea SHALL be 0 in every other state.
REQ-021 In RESP, for a read, the owner's rdata SHALL capture mem_dout, and the owner's ack SHALL pulse for exactly one cycle.
REQ-022 A write SHALL also complete with an ack in RESP; the latency from the IDLE grant cycle to ack is 2 cycles for both reads and writes.
REQ-023 core_rdata and dbg_rdata SHALL hold their last captured value until the next read by the same owner.
REQ-024 core_stall SHALL equal core_req AND NOT core_ack (combinational).
REQ-025 starve_cnt SHALL increment, saturating at STARVE_LIMIT, on each IDLE cycle where dbg_req=1 and the core wins.
- It SHALL clear when dbg is granted.
- It SHALL clear when dbg_req=0.
REQ-026 A requester that drops req after being latched SHALL still receive its ack; the access is never aborted.
REQ-027 Requests that are deasserted while not yet granted SHALL be ignored.
REQ-028 When both requests arrive in the same cycle, exactly one grant SHALL be issued; the loser SHALL be served in the next IDLE.
REQ-029 Requests asserted during ISSUE or RESP SHALL wait for IDLE; throughput is at most one access per 3 cycles.
REQ-030 Both ack outputs SHALL never be 1 in the same cycle.

Reset
REQ-031 Asserting Rst (0) SHALL put the FSM in IDLE immediately and clear all outputs.
- Cleared outputs: rdata, acks, mem_* outputs and counters all 0; core_stall then follows core_req.
- starve_cnt and the owner flag SHALL also clear.
REQ-032 Reset mid-transaction SHALL abort the access with no ack; a write in ISSUE SHALL have mem_wea forced to 0 asynchronously.
REQ-033 After Rst deasserts, the first arbitration SHALL occur on the first rising edge with the FSM in IDLE.

Configuration
REQ-034 The macro MEM_PORT_ARBITER_PERF_EN SHALL select whether the grant counters are built.
- Defined: core_gnt_cnt and dbg_gnt_cnt increment on each IDLE->ISSUE grant to their owner and saturate at all-ones.
- Undefined: both ports remain and are tied to 0; no counter flops are built.

Verification
REQ-035 Core read: core_req=1, we=0, addr=0x100, mem_dout=0xDEADBEEF -> mem_en=4'hF one cycle later; core_ack and core_rdata=0xDEADBEEF on the second cycle; core_stall=1 until ack.
REQ-036 Simultaneous requests: core write 0x0000_00AA to 0x10 and dbg read of 0x20 in the same cycle -> core acks at cycle 2 and dbg acks at cycle 5; acks are never coincident.
REQ-037 Starvation: core_req held high continuously, dbg_req=1, STARVE_LIMIT=8 -> dbg granted at the 9th arbitration, then starve_cnt=0.
REQ-038 Reset mid-op: Rst=0 during ISSUE of a core write -> mem_wea=0 immediately; no core_ack; FSM in IDLE after release.
REQ-039 Perf counters, with MEM_PORT_ARBITER_PERF_EN defined: 5 core grants and 3 dbg grants -> core_gnt_cnt=5, dbg_gnt_cnt=3; with the macro undefined, both counters are 0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates a core and a debug requester onto one shared data-memory port, one access per 3 cycles.
// Grant counters are built only when MEM_PORT_ARBITER_PERF_EN is defined; otherwise they read 0.
module mem_port_arbiter #(
   parameter int STARVE_LIMIT = 8,
   parameter int CNT_W        = 16
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_core_req,
   input  logic             i_core_we,
   input  logic [3:0]       i_core_en,
   input  logic [31:0]      i_core_addr,
   input  logic [31:0]      i_core_din,
   output logic [31:0]      o_core_rdata,
   output logic             o_core_ack,
   output logic             o_core_stall,
   input  logic             i_dbg_req,
   input  logic             i_dbg_we,
   input  logic [3:0]       i_dbg_en,
   input  logic [31:0]      i_dbg_addr,
   input  logic [31:0]      i_dbg_din,
   output logic [31:0]      o_dbg_rdata,
   output logic             o_dbg_ack,
   output logic [3:0]       o_mem_en,
   output logic             o_mem_wea,
   output logic             o_mem_rea,
   output logic [31:0]      o_mem_addr,
   output logic [31:0]      o_mem_din,
   input  logic [31:0]      i_mem_dout,
   output logic [CNT_W-1:0] o_core_gnt_cnt,
   output logic [CNT_W-1:0] o_dbg_gnt_cnt
);
   // state | meaning
   // IDLE  | arbitrate pending requests, latch the winner
   // ISSUE | drive the latched access onto the memory port
   // RESP  | ack the owner, return read data
   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ISSUE = 2'd1, ST_RESP = 2'd2} state_t;

   localparam int SW = $clog2(STARVE_LIMIT + 1);

   state_t        r_state, w_next;
   logic          r_owner, r_we;
   logic [3:0]    r_en;
   logic [31:0]   r_addr, r_din;
   logic [31:0]   r_core_rdata, r_dbg_rdata;
   logic [SW-1:0] r_starve;
   logic          w_grant, w_dbg_win, w_issue, w_resp, w_core_rd, w_dbg_rd;

   assign w_dbg_win = i_dbg_req && (!i_core_req || (r_starve == SW'(STARVE_LIMIT)));
   assign w_grant   = (r_state == ST_IDLE) && (i_core_req || i_dbg_req);
   assign w_issue   = (r_state == ST_ISSUE);
   assign w_resp    = (r_state == ST_RESP);
   assign w_core_rd = w_resp && !r_owner && !r_we;
   assign w_dbg_rd  = w_resp && r_owner && !r_we;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= ST_IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:  if (i_core_req || i_dbg_req) w_next = ST_ISSUE;
         ST_ISSUE: w_next = ST_RESP;
         ST_RESP:  w_next = ST_IDLE;
         default:  w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_owner <= 1'b0;
         r_we    <= 1'b0;
         r_en    <= 4'h0;
         r_addr  <= 32'h0;
         r_din   <= 32'h0;
      end else if (w_grant) begin
         r_owner <= w_dbg_win;
         r_we    <= w_dbg_win ? i_dbg_we   : i_core_we;
         r_en    <= w_dbg_win ? i_dbg_en   : i_core_en;
         r_addr  <= w_dbg_win ? i_dbg_addr : i_core_addr;
         r_din   <= w_dbg_win ? i_dbg_din  : i_core_din;
      end
   end

   // Starvation only advances on arbitration cycles the core wins while dbg waits.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_starve <= '0;
      end else if (!i_dbg_req) begin
         r_starve <= '0;
      end else if (w_grant) begin
         if (w_dbg_win)                           r_starve <= '0;
         else if (r_starve != SW'(STARVE_LIMIT))  r_starve <= r_starve + SW'(1);
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_core_rdata <= 32'h0;
         r_dbg_rdata  <= 32'h0;
      end else begin
         if (w_core_rd) r_core_rdata <= i_mem_dout;
         if (w_dbg_rd)  r_dbg_rdata  <= i_mem_dout;
      end
   end

   // Read data is passed through during RESP so it is valid together with the ack.
   assign o_core_rdata = w_core_rd ? i_mem_dout : r_core_rdata;
   assign o_dbg_rdata  = w_dbg_rd  ? i_mem_dout : r_dbg_rdata;
   assign o_core_ack   = w_resp && !r_owner;
   assign o_dbg_ack    = w_resp && r_owner;
   assign o_core_stall = i_core_req && !o_core_ack;

   assign o_mem_en   = w_issue ? r_en : 4'h0;
   assign o_mem_wea  = w_issue && r_we;
   assign o_mem_rea  = w_issue && !r_we;
   assign o_mem_addr = w_issue ? r_addr : 32'h0;
   assign o_mem_din  = w_issue ? r_din  : 32'h0;

`ifdef MEM_PORT_ARBITER_PERF_EN
   logic [CNT_W-1:0] r_core_cnt, r_dbg_cnt;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_core_cnt <= '0;
         r_dbg_cnt  <= '0;
      end else if (w_grant) begin
         if (w_dbg_win) begin
            if (r_dbg_cnt != '1) r_dbg_cnt <= r_dbg_cnt + CNT_W'(1);
         end else if (r_core_cnt != '1) begin
            r_core_cnt <= r_core_cnt + CNT_W'(1);
         end
      end
   end

   assign o_core_gnt_cnt = r_core_cnt;
   assign o_dbg_gnt_cnt  = r_dbg_cnt;
`else
   assign o_core_gnt_cnt = '0;
   assign o_dbg_gnt_cnt  = '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_mem_port_arbiter;
   localparam int LIMIT = 8;
   localparam int CNT_W = 16;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             core_req = 0, core_we = 0, dbg_req = 0, dbg_we = 0;
   logic [3:0]       core_en = 0, dbg_en = 0;
   logic [31:0]      core_addr = 0, core_din = 0, dbg_addr = 0, dbg_din = 0;
   logic [31:0]      core_rdata, dbg_rdata, mem_addr, mem_din, mem_dout;
   logic             core_ack, core_stall, dbg_ack, mem_wea, mem_rea;
   logic [3:0]       mem_en;
   logic [CNT_W-1:0] core_gnt_cnt, dbg_gnt_cnt;
   logic             init_mem = 1'b1;

   always #5 clk = ~clk;

   mem_port_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(CNT_W)) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_core_req(core_req), .i_core_we(core_we), .i_core_en(core_en),
      .i_core_addr(core_addr), .i_core_din(core_din),
      .o_core_rdata(core_rdata), .o_core_ack(core_ack), .o_core_stall(core_stall),
      .i_dbg_req(dbg_req), .i_dbg_we(dbg_we), .i_dbg_en(dbg_en),
      .i_dbg_addr(dbg_addr), .i_dbg_din(dbg_din),
      .o_dbg_rdata(dbg_rdata), .o_dbg_ack(dbg_ack),
      .o_mem_en(mem_en), .o_mem_wea(mem_wea), .o_mem_rea(mem_rea),
      .o_mem_addr(mem_addr), .o_mem_din(mem_din), .i_mem_dout(mem_dout),
      .o_core_gnt_cnt(core_gnt_cnt), .o_dbg_gnt_cnt(dbg_gnt_cnt)
   );

   function automatic logic [31:0] init_word(input int i);
      return (32'(i) * 32'h9E37_79B1) ^ 32'hC3A5_0F00;
   endfunction

   // memory attached to the shared port: read data appears one cycle after the access
   logic [31:0] mem_t [64];
   always @(posedge clk) begin
      if (init_mem) begin
         for (int i = 0; i < 64; i++) mem_t[i] <= init_word(i);
         mem_dout <= '0;
      end else begin
         if (mem_wea)
            for (int b = 0; b < 4; b++)
               if (mem_en[b]) mem_t[mem_addr[7:2]][8*b +: 8] <= mem_din[8*b +: 8];
         if (mem_rea) mem_dout <= mem_t[mem_addr[7:2]];
      end
   end

   int n_cmp = 0, n_err = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // reference model: one access in flight, issued the cycle after its grant, acked two cycles after
   int          cyc = 0, free_at = 0, starve = 0, core_cnt = 0, dbg_cnt = 0;
   bit          tx_valid = 0, tx_dbg, tx_we;
   logic [3:0]  tx_en;
   logic [31:0] tx_addr, tx_din;
   int          tx_issue, tx_ack;
   logic [31:0] mem_m [64];
   logic [31:0] last_core_rd = 0, last_dbg_rd = 0, core_ack_rd = 0;
   int          core_ack_cyc = -1, dbg_ack_cyc = -1, n_core_acks = 0, n_dbg_acks = 0;

   task automatic model_reset();
      tx_valid = 0; free_at = cyc; starve = 0; core_cnt = 0; dbg_cnt = 0;
      last_core_rd = 0; last_dbg_rd = 0;
   endtask

   task automatic cycle_check();
      logic [3:0]  e_en;
      logic        e_wea, e_rea, e_cack, e_dack, dwin;
      logic [31:0] rd;
      e_en = 4'h0; e_wea = 0; e_rea = 0; e_cack = 0; e_dack = 0;
      if (tx_valid && cyc == tx_issue) begin
         e_en = tx_en; e_wea = tx_we; e_rea = !tx_we;
         chk("mem_addr", mem_addr, tx_addr);
         chk("mem_din", mem_din, tx_din);
         if (tx_we)
            for (int b = 0; b < 4; b++)
               if (tx_en[b]) mem_m[tx_addr[7:2]][8*b +: 8] = tx_din[8*b +: 8];
      end
      if (tx_valid && cyc == tx_ack) begin
         if (tx_dbg) e_dack = 1; else e_cack = 1;
         if (!tx_we) begin
            rd = mem_m[tx_addr[7:2]];
            if (tx_dbg) last_dbg_rd = rd; else last_core_rd = rd;
         end
      end
      chk("mem_en", mem_en, e_en);
      chk("mem_wea", mem_wea, e_wea);
      chk("mem_rea", mem_rea, e_rea);
      chk("core_ack", core_ack, e_cack);
      chk("dbg_ack", dbg_ack, e_dack);
      chk("core_rdata", core_rdata, last_core_rd);
      chk("dbg_rdata", dbg_rdata, last_dbg_rd);
      chk("core_stall", core_stall, core_req & ~e_cack);
      chk("ack_exclusive", core_ack & dbg_ack, 0);
`ifdef MEM_PORT_ARBITER_PERF_EN
      chk("core_gnt_cnt", core_gnt_cnt, core_cnt);
      chk("dbg_gnt_cnt", dbg_gnt_cnt, dbg_cnt);
`else
      chk("core_gnt_cnt", core_gnt_cnt, 0);
      chk("dbg_gnt_cnt", dbg_gnt_cnt, 0);
`endif
      if (core_ack) begin core_ack_cyc = cyc; core_ack_rd = core_rdata; n_core_acks++; end
      if (dbg_ack) begin dbg_ack_cyc = cyc; n_dbg_acks++; end
      if (cyc >= free_at) begin
         dwin = dbg_req && (!core_req || starve == LIMIT);
         if (core_req || dbg_req) begin
            tx_valid = 1; tx_dbg = dwin;
            tx_we   = dwin ? dbg_we   : core_we;
            tx_en   = dwin ? dbg_en   : core_en;
            tx_addr = dwin ? dbg_addr : core_addr;
            tx_din  = dwin ? dbg_din  : core_din;
            tx_issue = cyc + 1; tx_ack = cyc + 2; free_at = cyc + 3;
            if (dwin) begin if (dbg_cnt < 65535) dbg_cnt++; end
            else if (core_cnt < 65535) core_cnt++;
         end
         if (!dbg_req || dwin) starve = 0;
         else if (starve < LIMIT) starve++;
      end else if (!dbg_req) begin
         starve = 0;
      end
      cyc++;
   endtask

   // entered at posedge+1 with inputs set; leaves at the next posedge+1
   task automatic step();
      #1;
      cycle_check();
      @(posedge clk);
      #1;
   endtask

   task automatic do_txn(input bit d, input bit we, input logic [31:0] addr, input logic [31:0] din);
      if (d) begin dbg_req = 1; dbg_we = we; dbg_en = 4'hF; dbg_addr = addr; dbg_din = din; end
      else   begin core_req = 1; core_we = we; core_en = 4'hF; core_addr = addr; core_din = din; end
      step();
      core_req = 0; dbg_req = 0;
      step();
      step();
   endtask

   task automatic drive_random();
      bit c_done, c_lat, d_done, d_lat;
      c_done = tx_valid && !tx_dbg && (tx_ack == cyc - 1);
      c_lat  = tx_valid && !tx_dbg && (cyc <= tx_ack);
      d_done = tx_valid && tx_dbg && (tx_ack == cyc - 1);
      d_lat  = tx_valid && tx_dbg && (cyc <= tx_ack);
      if (core_req) begin
         if (c_done) core_req = 0;
         else if (c_lat) begin if ($urandom_range(7) == 0) core_req = 0; end
         else if ($urandom_range(15) == 0) core_req = 0;
      end else if ($urandom_range(2) == 0) begin
         core_req = 1; core_we = 1'($urandom_range(1)); core_en = 4'($urandom_range(15));
         core_addr = $urandom & 32'hFFFF_FFFC; core_din = $urandom;
      end
      if (dbg_req) begin
         if (d_done) dbg_req = 0;
         else if (d_lat) begin if ($urandom_range(7) == 0) dbg_req = 0; end
         else if ($urandom_range(15) == 0) dbg_req = 0;
      end else if ($urandom_range(2) == 0) begin
         dbg_req = 1; dbg_we = 1'($urandom_range(1)); dbg_en = 4'($urandom_range(15));
         dbg_addr = $urandom & 32'hFFFF_FFFC; dbg_din = $urandom;
      end
   endtask

   initial begin
      int g, base, exp_c, exp_d;
      for (int i = 0; i < 64; i++) mem_m[i] = init_word(i);

      // outputs while held in reset
      repeat (2) @(posedge clk);
      #1;
      core_req = 1;
      #1;
      chk("rst_core_stall", core_stall, 1);
      chk("rst_core_ack", core_ack, 0);
      chk("rst_dbg_ack", dbg_ack, 0);
      chk("rst_mem_en", mem_en, 0);
      chk("rst_mem_wea", mem_wea, 0);
      chk("rst_mem_rea", mem_rea, 0);
      chk("rst_core_rdata", core_rdata, 0);
      chk("rst_dbg_rdata", dbg_rdata, 0);
      chk("rst_cnts", {core_gnt_cnt, dbg_gnt_cnt}, 0);
      core_req = 0;
      @(posedge clk);
      #1;
      init_mem = 0;
      rst_n = 1;

      // dbg writes DEADBEEF at 0x100, then core reads it back with 2-cycle latency
      step();
      do_txn(1, 1, 32'h100, 32'hDEAD_BEEF);
      g = cyc;
      core_req = 1; core_we = 0; core_en = 4'hF; core_addr = 32'h100;
      step();
      chk("035_mem_en_issue", mem_en, 4'hF);
      chk("035_stall_before_ack", core_stall, 1);
      step();
      step();
      core_req = 0;
      chk("035_ack_latency", core_ack_cyc - g, 2);
      chk("035_rdata", core_ack_rd, 32'hDEAD_BEEF);

      // simultaneous core write and dbg read
      core_req = 1; core_we = 1; core_en = 4'hF; core_addr = 32'h10; core_din = 32'hAA;
      dbg_req = 1; dbg_we = 0; dbg_en = 4'hF; dbg_addr = 32'h20;
      g = cyc;
      step(); step(); step();
      core_req = 0;
      step(); step(); step();
      dbg_req = 0;
      chk("036_core_ack_cycle", core_ack_cyc - g, 2);
      chk("036_dbg_ack_cycle", dbg_ack_cyc - g, 5);

      // starvation: core held continuously, dbg held
      step();
      n_core_acks = 0; n_dbg_acks = 0;
      core_req = 1; core_we = 0; core_en = 4'hF; core_addr = 32'h80;
      dbg_req = 1; dbg_we = 0; dbg_en = 4'hF; dbg_addr = 32'h84;
      for (int i = 0; i < 60 && n_dbg_acks < 1; i++) step();
      chk("037_dbg_granted", n_dbg_acks, 1);
      chk("037_core_wins_before_dbg", n_core_acks, 8);
      base = n_core_acks;
      for (int i = 0; i < 60 && n_dbg_acks < 2; i++) step();
      chk("037_starve_cleared", n_core_acks - base, 8);
      core_req = 0; dbg_req = 0;
      step();

      // reset during ISSUE of a core write
      do_txn(0, 1, 32'h40, 32'h1234_5678);
      core_req = 1; core_we = 1; core_en = 4'hF; core_addr = 32'h40; core_din = 32'h5555_AAAA;
      step();
      chk("038_wea_in_issue", mem_wea, 1);
      rst_n = 0;
      #1;
      chk("038_wea_forced", mem_wea, 0);
      chk("038_en_forced", mem_en, 0);
      core_req = 0;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk);
         #1;
         chk("038_no_ack", core_ack, 0);
      end
      rst_n = 1;
      model_reset();
      g = cyc;
      core_req = 1; core_we = 0; core_en = 4'hF; core_addr = 32'h40;
      step();
      core_req = 0;
      step(); step();
      chk("038_idle_after_release", core_ack_cyc - g, 2);
      chk("038_write_aborted", core_ack_rd, 32'h1234_5678);

      // 5 core + 3 dbg grants since reset (the read above is one of the core grants)
      for (int i = 0; i < 4; i++) do_txn(0, 0, 32'($urandom_range(63)) << 2, 32'h0);
      for (int i = 0; i < 3; i++) do_txn(1, 1, 32'($urandom_range(63)) << 2, $urandom);
`ifdef MEM_PORT_ARBITER_PERF_EN
      exp_c = 5; exp_d = 3;
`else
      exp_c = 0; exp_d = 0;
`endif
      chk("039_core_gnt_cnt", core_gnt_cnt, exp_c);
      chk("039_dbg_gnt_cnt", dbg_gnt_cnt, exp_d);

      for (int i = 0; i < 400; i++) begin
         drive_random();
         step();
      end
      core_req = 0; dbg_req = 0;
      repeat (4) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
